mesi_directory_snoop_ctrl: RTL
==============================

# mesi_directory_snoop_ctrl

Parametrised MESI coherency engine between N private L1 caches and the shared L2. It replaces broadcast snooping with directory-filtered snooping and round-robin request arbitration. It grants E/S/M states, forwards dirty snoop data, and writes back downgraded dirty lines. A per-transaction timeout guarantees forward progress.

## Interface
- NUM_CORES, 4, number of L1 requesters (≥2)
- ADDR_W, 32, line address width
- LINE_W, 512, cache line data width
- ID_W, 4, request tag width
- TIMEOUT_CYCLES, 256, maximum cycles from entering SNOOP to all responses received
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_CORES  per-core request valid
- req_ready_o  out  NUM_CORES  per-core request accept
- req_type_i  in  2*NUM_CORES  request type per core: 0 READ_SHARED, 1 READ_UNIQUE, 2 UPGRADE, 3 reserved
- req_addr_i  in  ADDR_W*NUM_CORES  request line address per core
- req_id_i  in  ID_W*NUM_CORES  request tag per core
- dir_addr_o  out  ADDR_W  directory lookup address
- dir_sharers_i  in  NUM_CORES  directory sharer mask; combinational response to dir_addr_o
- dir_upd_valid_o  out  1  directory write strobe (single cycle)
- dir_upd_sharers_o  out  NUM_CORES  new sharer mask for dir_addr_o
- snoop_valid_o  out  NUM_CORES  per-core snoop valid
- snoop_ready_i  in  NUM_CORES  per-core snoop accept
- snoop_addr_o  out  ADDR_W  snoop address, shared by all cores
- snoop_inv_o  out  1  1 = invalidate, 0 = downgrade to S
- snoop_rsp_valid_i  in  NUM_CORES  snoop response valid
- snoop_rsp_dirty_i  in  NUM_CORES  response carries modified data
- snoop_rsp_data_i  in  LINE_W*NUM_CORES  response data
- wb_valid_o / wb_ready_i  out/in  1  L2 writeback handshake
- wb_addr_o, wb_data_o  out  ADDR_W, LINE_W  writeback payload
- rsp_valid_o  out  NUM_CORES  response valid to the requester only
- rsp_ready_i  in  NUM_CORES  response accept
- rsp_id_o, rsp_data_o  out  ID_W, LINE_W  response tag and forwarded data
- rsp_data_valid_o  out  1  rsp_data_o is valid (forwarded dirty line)
- rsp_state_o  out  2  granted state: 0 I, 1 S, 2 E, 3 M
- rsp_error_o  out  1  snoop timeout occurred

## Operation
- FSM states: IDLE, LOOKUP, SNOOP, COLLECT, WRITEBACK, RESPOND. Reset state is IDLE.
- **IDLE**
  - If any req_valid_i is high, the first valid core at or after arb_ptr (mod NUM_CORES) gets req_ready_o in the same cycle.
  - Type, addr, id and core are captured; arb_ptr becomes granted+1 mod NUM_CORES; next state is LOOKUP.
  - Type 3 is accepted and goes directly to RESPOND with rsp_error_o=1 and rsp_state_o=I.
- **LOOKUP**
  - dir_addr_o = captured addr.
  - targets = dir_sharers_i & ~requester_bit.
  - targets==0 → RESPOND; otherwise SNOOP. The timeout counter is cleared.
- **SNOOP**
  - snoop_valid_o = snoop_pend, initialised to targets.
  - snoop_inv_o = (type != READ_SHARED).
  - Each snoop_valid&snoop_ready clears its pend bit. When pend is 0 → COLLECT.
- **Response collection (SNOOP and COLLECT)**
  - rsp_pend is initialised to targets. snoop_rsp_valid_i[i] clears bit i only if that bit is set; responses from other cores are ignored.
  - The first dirty response is captured. On simultaneous dirty responses, the lowest index wins.
  - A response may arrive in the same cycle as its snoop handshake.
- **COLLECT exit**
  - rsp_pend==0 → WRITEBACK if type==READ_SHARED and dirty data was captured; otherwise RESPOND.
- **Timeout**
  - The counter increments every cycle in SNOOP/COLLECT.
  - When it reaches TIMEOUT_CYCLES-1 with work still pending: drop snoop_valid_o, go to RESPOND with error=1, state=I, no data, no directory update.
- **WRITEBACK**: wb_valid_o held with captured addr/data until wb_ready_i, then RESPOND.
- **RESPOND**
  - rsp_valid_o[requester] is held until rsp_ready_i.
  - Granted state by type:
    - READ_SHARED: S if targets≠0, else E.
    - READ_UNIQUE: M if dirty captured, else E.
    - UPGRADE: M.
  - rsp_data_valid_o = dirty captured and type≠UPGRADE.
  - Directory update (non-error only): dir_upd_valid_o pulses in the handshake cycle.
    - dir_upd_sharers_o = targets|req_bit for READ_SHARED, req_bit otherwise.
  - After the handshake → IDLE.

## Timing
- All outputs and the arbiter pointer reset to 0. Data outputs are zero when not valid.
- Minimum latency, no sharers: accept (cycle 0) → LOOKUP (1) → rsp_valid_o (2).
- With sharers, all snoop_ready and rsp immediate: accept 0, LOOKUP 1, SNOOP 2, COLLECT 3, RESPOND 4.
- At most one transaction is in flight. req_ready_o is 0 outside IDLE.
- Valid signals do not drop before their handshake, except snoop_valid_o on timeout.
- Asynchronous reset mid-transaction aborts it. Outstanding snoops are abandoned and no directory update is issued.
- arb_ptr wraps from NUM_CORES-1 to 0.

## Test plan
- Core1 READ_SHARED to 0x100, dir_sharers=0 → rsp_valid_o[1] at cycle 2, state=E, data_valid=0, dir_upd_sharers=0b0010.
- Core0 READ_SHARED, sharers=0b0100, core2 responds dirty with data 0xA5.. → snoop_inv_o=0, wb_valid_o with 0xA5.., then rsp state=S, data_valid=1, dir_upd=0b0101.
- Core3 READ_UNIQUE, sharers=0b0111, core1 dirty and core2 clean in the same cycle → invalidate snoops to cores 0–2, state=M, data from core1, dir_upd=0b1000, no writeback.
- All four cores request simultaneously, repeated → grants 0,1,2,3,0 in order; arb_ptr wraps correctly.
- UPGRADE with sharers=0b0010, core1 never responds, TIMEOUT_CYCLES=8 → rsp_error_o=1 exactly 8 cycles after SNOOP entry, state=I, no dir_upd_valid_o.
- Reset asserted during COLLECT → all outputs 0 immediately; the next request is granted from core0.

Source files
------------

// File: rtl/mesi_directory_snoop_ctrl_if.sv
// Bus bundle for the MESI directory snoop controller.
// master: controller side (accepts requests, drives snoops, writebacks, responses).
// slave: environment side (L1 requesters, directory, L1 snoop ports, L2).
interface mesi_directory_snoop_ctrl_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 512,
    parameter int ID_W      = 4
);
    logic [NUM_CORES-1:0]        req_valid_i;
    logic [NUM_CORES-1:0]        req_ready_o;
    logic [2*NUM_CORES-1:0]      req_type_i;
    logic [ADDR_W*NUM_CORES-1:0] req_addr_i;
    logic [ID_W*NUM_CORES-1:0]   req_id_i;

    logic [ADDR_W-1:0]           dir_addr_o;
    logic [NUM_CORES-1:0]        dir_sharers_i;
    logic                        dir_upd_valid_o;
    logic [NUM_CORES-1:0]        dir_upd_sharers_o;

    logic [NUM_CORES-1:0]        snoop_valid_o;
    logic [NUM_CORES-1:0]        snoop_ready_i;
    logic [ADDR_W-1:0]           snoop_addr_o;
    logic                        snoop_inv_o;
    logic [NUM_CORES-1:0]        snoop_rsp_valid_i;
    logic [NUM_CORES-1:0]        snoop_rsp_dirty_i;
    logic [LINE_W*NUM_CORES-1:0] snoop_rsp_data_i;

    logic                        wb_valid_o;
    logic                        wb_ready_i;
    logic [ADDR_W-1:0]           wb_addr_o;
    logic [LINE_W-1:0]           wb_data_o;

    logic [NUM_CORES-1:0]        rsp_valid_o;
    logic [NUM_CORES-1:0]        rsp_ready_i;
    logic [ID_W-1:0]             rsp_id_o;
    logic [LINE_W-1:0]           rsp_data_o;
    logic                        rsp_data_valid_o;
    logic [1:0]                  rsp_state_o;
    logic                        rsp_error_o;

    modport master (
        input  req_valid_i, req_type_i, req_addr_i, req_id_i,
        output req_ready_o,
        output dir_addr_o, dir_upd_valid_o, dir_upd_sharers_o,
        input  dir_sharers_i,
        output snoop_valid_o, snoop_addr_o, snoop_inv_o,
        input  snoop_ready_i, snoop_rsp_valid_i, snoop_rsp_dirty_i,
        input  snoop_rsp_data_i,
        output wb_valid_o, wb_addr_o, wb_data_o,
        input  wb_ready_i,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_data_valid_o,
        output rsp_state_o, rsp_error_o,
        input  rsp_ready_i
    );

    modport slave (
        output req_valid_i, req_type_i, req_addr_i, req_id_i,
        input  req_ready_o,
        input  dir_addr_o, dir_upd_valid_o, dir_upd_sharers_o,
        output dir_sharers_i,
        input  snoop_valid_o, snoop_addr_o, snoop_inv_o,
        output snoop_ready_i, snoop_rsp_valid_i, snoop_rsp_dirty_i,
        output snoop_rsp_data_i,
        input  wb_valid_o, wb_addr_o, wb_data_o,
        output wb_ready_i,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_data_valid_o,
        input  rsp_state_o, rsp_error_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/mesi_directory_snoop_ctrl.sv
// MESI coherency engine: round-robin request arbiter, directory-filtered
// snooping, dirty-data forwarding, L2 writeback and snoop timeout.
// Ports: clk_i, rst_ni (async, active-low), bus (master modport of
// mesi_directory_snoop_ctrl_if carrying request/dir/snoop/wb/rsp channels).
module mesi_directory_snoop_ctrl #(
    parameter int NUM_CORES      = 4,
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 512,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                         clk_i,
    input logic                         rst_ni,
    mesi_directory_snoop_ctrl_if.master bus
);
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RD_SHARED = 2'd0;
    localparam logic [1:0] RD_UNIQUE = 2'd1;
    localparam logic [1:0] UPGRADE   = 2'd2;
    localparam logic [1:0] RSVD      = 2'd3;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, SNOOP, COLLECT, WRITEBACK, RESPOND
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        arb_ptr_q, arb_ptr_d;
    logic [CW-1:0]        core_q, core_d;
    logic [1:0]           type_q, type_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [NUM_CORES-1:0] targets_q, targets_d;
    logic [NUM_CORES-1:0] snoop_pend_q, snoop_pend_d;
    logic [NUM_CORES-1:0] rsp_pend_q, rsp_pend_d;
    logic                 dirty_q, dirty_d;
    logic                 err_q, err_d;
    logic [LINE_W-1:0]    data_q, data_d;
    logic [TW-1:0]        tmo_q, tmo_d;

    logic                 gnt_any;
    logic [CW-1:0]        gnt_idx;
    logic [CW:0]          cand;
    logic [NUM_CORES-1:0] req_bit;
    logic [NUM_CORES-1:0] hit;
    logic [CW-1:0]        hit_idx;
    logic [LINE_W-1:0]    hit_data;
    logic                 fwd_data;

    // Walk the cores from arb_ptr upward with wrap; iterating backwards
    // lets the nearest valid core overwrite any farther one.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            cand = {1'b0, arb_ptr_q} + (CW+1)'(i);
            if (cand >= (CW+1)'(NUM_CORES)) begin
                cand = cand - (CW+1)'(NUM_CORES);
            end
            if (bus.req_valid_i[cand[CW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[CW-1:0];
            end
        end
    end

    // Only responses from still-pending targets count; lowest dirty index wins.
    always_comb begin
        req_bit          = '0;
        req_bit[core_q]  = 1'b1;
        hit     = bus.snoop_rsp_valid_i & bus.snoop_rsp_dirty_i & rsp_pend_q;
        hit_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = CW'(i);
            end
        end
        hit_data = bus.snoop_rsp_data_i[int'(hit_idx)*LINE_W +: LINE_W];
        fwd_data = dirty_q && (type_q != UPGRADE);
    end

    always_comb begin
        state_d      = state_q;
        arb_ptr_d    = arb_ptr_q;
        core_d       = core_q;
        type_d       = type_q;
        addr_d       = addr_q;
        id_d         = id_q;
        targets_d    = targets_q;
        snoop_pend_d = snoop_pend_q;
        rsp_pend_d   = rsp_pend_q;
        dirty_d      = dirty_q;
        err_d        = err_q;
        data_d       = data_q;
        tmo_d        = tmo_q;

        bus.req_ready_o       = '0;
        bus.dir_addr_o        = '0;
        bus.dir_upd_valid_o   = 1'b0;
        bus.dir_upd_sharers_o = '0;
        bus.snoop_valid_o     = '0;
        bus.snoop_addr_o      = '0;
        bus.snoop_inv_o       = 1'b0;
        bus.wb_valid_o        = 1'b0;
        bus.wb_addr_o         = '0;
        bus.wb_data_o         = '0;
        bus.rsp_valid_o       = '0;
        bus.rsp_id_o          = '0;
        bus.rsp_data_o        = '0;
        bus.rsp_data_valid_o  = 1'b0;
        bus.rsp_state_o       = ST_I;
        bus.rsp_error_o       = 1'b0;

        if (state_q == SNOOP || state_q == COLLECT) begin
            rsp_pend_d = rsp_pend_q & ~bus.snoop_rsp_valid_i;
            tmo_d      = tmo_q + 1'b1;
            if (!dirty_q && (|hit)) begin
                dirty_d = 1'b1;
                data_d  = hit_data;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    bus.req_ready_o[gnt_idx] = 1'b1;
                    core_d       = gnt_idx;
                    type_d       = bus.req_type_i[int'(gnt_idx)*2 +: 2];
                    addr_d       = bus.req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
                    id_d         = bus.req_id_i[int'(gnt_idx)*ID_W +: ID_W];
                    arb_ptr_d    = (gnt_idx == CW'(NUM_CORES - 1)) ?
                                   '0 : gnt_idx + 1'b1;
                    targets_d    = '0;
                    snoop_pend_d = '0;
                    rsp_pend_d   = '0;
                    dirty_d      = 1'b0;
                    err_d        = 1'b0;
                    if (bus.req_type_i[int'(gnt_idx)*2 +: 2] == RSVD) begin
                        err_d   = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                bus.dir_addr_o = addr_q;
                targets_d      = bus.dir_sharers_i & ~req_bit;
                snoop_pend_d   = targets_d;
                rsp_pend_d     = targets_d;
                tmo_d          = '0;
                state_d        = (targets_d == '0) ? RESPOND : SNOOP;
            end
            SNOOP: begin
                bus.snoop_valid_o = snoop_pend_q;
                bus.snoop_addr_o  = addr_q;
                bus.snoop_inv_o   = (type_q != RD_SHARED);
                snoop_pend_d      = snoop_pend_q & ~bus.snoop_ready_i;
                if (tmo_q >= TMO_LAST &&
                    (snoop_pend_d != '0 || rsp_pend_d != '0)) begin
                    err_d   = 1'b1;
                    dirty_d = 1'b0;
                    state_d = RESPOND;
                end else if (snoop_pend_d == '0) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (rsp_pend_q == '0) begin
                    state_d = (type_q == RD_SHARED && dirty_q) ?
                              WRITEBACK : RESPOND;
                end else if (tmo_q >= TMO_LAST && rsp_pend_d != '0) begin
                    err_d   = 1'b1;
                    dirty_d = 1'b0;
                    state_d = RESPOND;
                end
            end
            WRITEBACK: begin
                bus.wb_valid_o = 1'b1;
                bus.wb_addr_o  = addr_q;
                bus.wb_data_o  = data_q;
                if (bus.wb_ready_i) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                bus.rsp_valid_o      = req_bit;
                bus.rsp_id_o         = id_q;
                bus.rsp_error_o      = err_q;
                bus.rsp_data_valid_o = fwd_data;
                bus.rsp_data_o       = fwd_data ? data_q : '0;
                if (err_q) begin
                    bus.rsp_state_o = ST_I;
                end else begin
                    bus.dir_addr_o = addr_q;
                    unique case (type_q)
                        RD_SHARED: bus.rsp_state_o =
                                   (targets_q != '0) ? ST_S : ST_E;
                        RD_UNIQUE: bus.rsp_state_o = dirty_q ? ST_M : ST_E;
                        default:   bus.rsp_state_o = ST_M;
                    endcase
                end
                if (bus.rsp_ready_i[core_q]) begin
                    state_d = IDLE;
                    if (!err_q) begin
                        bus.dir_upd_valid_o   = 1'b1;
                        bus.dir_upd_sharers_o = (type_q == RD_SHARED) ?
                                                (targets_q | req_bit) : req_bit;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            arb_ptr_q    <= '0;
            core_q       <= '0;
            type_q       <= '0;
            addr_q       <= '0;
            id_q         <= '0;
            targets_q    <= '0;
            snoop_pend_q <= '0;
            rsp_pend_q   <= '0;
            dirty_q      <= 1'b0;
            err_q        <= 1'b0;
            data_q       <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            arb_ptr_q    <= arb_ptr_d;
            core_q       <= core_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            id_q         <= id_d;
            targets_q    <= targets_d;
            snoop_pend_q <= snoop_pend_d;
            rsp_pend_q   <= rsp_pend_d;
            dirty_q      <= dirty_d;
            err_q        <= err_d;
            data_q       <= data_d;
            tmo_q        <= tmo_d;
        end
    end
endmodule
